led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_led_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: STOP/RUN/HOLD control, prescaled auto-advance, manual step.
// state | meaning: ST_STOP idle, LEDs dark | ST_RUN auto-advance on tick | ST_HOLD frozen, step advances
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic       clr,
    input  logic [1:0] mode,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       tick,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nxt;
    logic [1:0]       w_phase_inc;
    logic [2:0]       r_led;
    logic [2:0]       w_led_nxt;
    logic             r_tick;
    logic             r_step;
    logic             r_armed;
    logic [1:0]       r_mode;
    logic             w_step_edge;
    logic             w_mode_chg;
    logic             w_tick;
    logic             w_adv;

    function automatic logic [2:0] led_decode(input logic [1:0] f_mode, input logic [1:0] f_phase);
        logic [2:0] v;
        v = 3'b000;
        case ({f_mode, f_phase})
            4'b00_00: v = 3'b001;
            4'b00_01: v = 3'b010;
            4'b00_10: v = 3'b100;
            4'b00_11: v = 3'b000;
            4'b01_00: v = 3'b001;
            4'b01_01: v = 3'b010;
            4'b01_10: v = 3'b100;
            4'b01_11: v = 3'b010;
            4'b10_00: v = 3'b111;
            4'b10_01: v = 3'b000;
            4'b10_10: v = 3'b111;
            4'b10_11: v = 3'b000;
            4'b11_00: v = 3'b001;
            4'b11_01: v = 3'b011;
            4'b11_10: v = 3'b111;
            4'b11_11: v = 3'b000;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // r_armed masks a step that was already high when reset released
        w_step_edge = step & ~r_step & r_armed;
        w_mode_chg  = (mode != r_mode);
        w_tick      = (r_state == ST_RUN) & run & (r_cnt == LP_CNT_LAST) & ~clr;
        w_adv       = w_tick | ((r_state == ST_HOLD) & w_step_edge & ~clr);

        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_STOP;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (run) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_step_edge) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_RUN:  if (!run) w_state_nxt = ST_HOLD;
                ST_HOLD: if (run)  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_STOP;
            endcase
        end

        w_cnt_nxt = '0;
        if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            w_cnt_nxt = (r_cnt == LP_CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end

        w_phase_inc = (r_mode == 2'd2) ? {1'b0, ~r_phase[0]} : r_phase + 2'd1;
        w_phase_nxt = r_phase;
        if ((w_state_nxt == ST_STOP) || w_mode_chg) begin
            w_phase_nxt = 2'd0;
        end else if (w_adv) begin
            w_phase_nxt = w_phase_inc;
        end

        w_led_nxt = (w_state_nxt == ST_STOP) ? 3'b000 : led_decode(mode, w_phase_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 2'd0;
            r_led   <= 3'b000;
            r_tick  <= 1'b0;
            r_step  <= 1'b0;
            r_armed <= 1'b0;
            r_mode  <= 2'd0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
            r_tick  <= w_tick;
            r_step  <= step;
            r_armed <= 1'b1;
            r_mode  <= mode;
        end
    end

    assign {LED2, LED1, LED0} = r_led;
    assign tick               = r_tick;
    assign phase              = r_phase;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_led_seq_ctrl;

    localparam int TD = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       run  = 1'b0;
    logic       step = 1'b0;
    logic       clr  = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       LED0, LED1, LED2, tick;
    logic [1:0] phase;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;

    // reference model state
    int         m_state;
    int         m_run_cycles;
    int         m_phase;
    int         m_mode;
    bit         m_prev_step;
    bit         m_armed;
    logic [2:0] pat [4][4];
    int         plen [4];
    logic [5:0] exp_q [$];
    logic [2:0] walk [4];

    led_seq_ctrl #(.TICK_DIV(TD), .CNT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .step  (step),
        .clr   (clr),
        .mode  (mode),
        .LED0  (LED0),
        .LED1  (LED1),
        .LED2  (LED2),
        .tick  (tick),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc_no, act, exp);
    endtask

    task automatic chk(input string name, input logic [2:0] l, input logic t, input logic [1:0] p);
        check(name, {LED2, LED1, LED0, tick, phase}, {l, t, p});
    endtask

    task automatic model_reset();
        m_state      = 0;
        m_run_cycles = 0;
        m_phase      = 0;
        m_mode       = 0;
        m_prev_step  = 1'b0;
        m_armed      = 1'b0;
    endtask

    // states: 0 stop, 1 run, 2 hold; m_run_cycles counts cycles since entering run
    task automatic model_step(input logic r, input logic s, input logic c, input logic [1:0] m);
        bit         edge_s, tk, adv;
        int         ns;
        logic [2:0] led;
        edge_s = s && !m_prev_step && m_armed;
        tk  = 1'b0;
        adv = 1'b0;
        ns  = m_state;
        if (c) begin
            ns           = 0;
            m_phase      = 0;
            m_run_cycles = 0;
        end else begin
            tk  = (m_state == 1) && r && ((m_run_cycles % TD) == TD - 1);
            adv = tk || (m_state == 2 && edge_s);
            case (m_state)
                0: if (r) ns = 1; else if (edge_s) ns = 2;
                1: if (!r) ns = 2;
                2: if (r) ns = 1;
                default: ns = 0;
            endcase
            if (int'(m) != m_mode) m_phase = 0;
            else if (adv) m_phase = (m_phase + 1) % plen[m_mode];
            m_run_cycles = (m_state == 1 && ns == 1) ? m_run_cycles + 1 : 0;
        end
        m_state     = ns;
        m_mode      = int'(m);
        m_prev_step = s;
        m_armed     = 1'b1;
        led = (m_state == 0) ? 3'b000 : pat[m][m_phase];
        exp_q.push_back({led, tk, 2'(m_phase)});
    endtask

    task automatic cyc(input logic r, input logic s, input logic c, input logic [1:0] m);
        @(negedge clk);
        rst  = 1'b0;
        run  = r;
        step = s;
        clr  = c;
        mode = m;
        model_step(r, s, c, m);
        @(posedge clk);
        cyc_no++;
        #2;
    endtask

    always @(posedge clk) begin
        logic [5:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {LED2, LED1, LED0, tick, phase}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [2:0] bexp [5];
        logic [1:0] bph  [5];
        logic       r;
        logic       s;
        logic       c;
        logic [1:0] m;

        pat[0] = '{3'b001, 3'b010, 3'b100, 3'b000};
        pat[1] = '{3'b001, 3'b010, 3'b100, 3'b010};
        pat[2] = '{3'b111, 3'b000, 3'b111, 3'b000};
        pat[3] = '{3'b001, 3'b011, 3'b111, 3'b000};
        plen   = '{4, 4, 2, 4};
        walk   = '{3'b001, 3'b010, 3'b100, 3'b000};
        bexp   = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
        bph    = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        model_reset();

        // reset state, step held high through release
        #3;
        chk("reset_state", 3'b000, 1'b0, 2'd0);
        step = 1'b1;
        cyc(0, 1, 0, 0);
        chk("step_thru_rst", 3'b000, 1'b0, 2'd0);
        cyc(0, 1, 0, 0);
        chk("step_thru_rst2", 3'b000, 1'b0, 2'd0);
        cyc(0, 0, 0, 0);

        // walk from STOP
        for (int k = 0; k <= 16; k++) begin
            cyc(1, 0, 0, 0);
            chk("walk", walk[(k / 4) % 4], (k > 0) && (k % 4 == 0), 2'((k / 4) % 4));
        end
        cyc(0, 0, 1, 0);
        chk("clr_stop", 3'b000, 1'b0, 2'd0);

        // bounce for five ticks
        cyc(1, 0, 0, 1);
        chk("bounce_entry", 3'b001, 1'b0, 2'd0);
        for (int k = 1; k <= 20; k++) begin
            cyc(1, 0, 0, 1);
            if (k % 4 == 0) chk("bounce", bexp[k / 4 - 1], 1'b1, bph[k / 4 - 1]);
        end
        cyc(0, 0, 1, 1);

        // run drops at prescaler terminal count, then three manual steps
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("run_drop", 3'b001, 1'b0, 2'd0);
        for (int p = 0; p < 3; p++) begin
            cyc(0, 1, 0, 0);
            chk("hold_step", walk[p + 1], 1'b0, 2'(p + 1));
            cyc(0, 0, 0, 0);
        end
        cyc(0, 0, 1, 0);

        // mode change walk->blink while running at phase 2
        for (int k = 0; k <= 8; k++) cyc(1, 0, 0, 0);
        chk("pre_mode_chg", 3'b100, 1'b1, 2'd2);
        for (int k = 9; k <= 16; k++) begin
            cyc(1, 0, 0, 2);
            if (k == 9)  chk("mode_chg", 3'b111, 1'b0, 2'd0);
            if (k == 12) chk("blink_a", 3'b000, 1'b1, 2'd1);
            if (k == 16) chk("blink_b", 3'b111, 1'b1, 2'd0);
        end
        cyc(0, 0, 1, 2);

        // clr coincident with tick and step edge; step behaviour in STOP and RUN
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        chk("clr_tick", 3'b000, 1'b0, 2'd0);
        cyc(0, 1, 0, 0);
        chk("step_held_clr", 3'b000, 1'b0, 2'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("stop_step_hold", 3'b001, 1'b0, 2'd0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("run_step_ignored", 3'b001, 1'b0, 2'd0);
        cyc(0, 0, 1, 0);

        // asynchronous reset mid-RUN while tick is high
        for (int k = 0; k <= 4; k++) cyc(1, 0, 0, 0);
        chk("pre_async_rst", 3'b010, 1'b1, 2'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", 3'b000, 1'b0, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            cyc(1, 0, 0, 0);
            if (k < 4) chk("rst_release", 3'b001, 1'b0, 2'd0);
            else       chk("rst_release_tick", 3'b010, 1'b1, 2'd1);
        end

        // randomized traffic, checked only by the scoreboard
        r = 1'b1;
        m = 2'd0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) r = ~r;
            s = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
            cyc(r, s, c, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
